// File: rtl/mux_rr_arbiter.sv
// Four-way round-robin arbiter driving a registered 4-to-1 data mux.
// Define MUX_ARB_BURST_LIMIT_EN to cap one grant at BURST_MAX cycles while others wait.
module mux_rr_arbiter #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       out,
    output logic       out_valid
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [1:0] last;
    logic [1:0] cur_idx;
    logic [3:0] data;
    logic [3:0] others;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_found;
    logic       cur_req;
    logic       release_gnt;
    logic       take_gnt;
`ifdef MUX_ARB_BURST_LIMIT_EN
    logic [3:0] burst_cnt;
    logic       burst_end;
`endif

    // The select lines double as the index of the current grant.
    assign cur_idx = {s0, s1};
    assign data    = {d, c, b, a};
    assign cur_req = req[cur_idx];
    assign others  = req & ~gnt;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        cand      = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!win_found && others[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_gnt = (state == BUSY) && !cur_req;

`ifdef MUX_ARB_BURST_LIMIT_EN
    assign burst_end = (state == BUSY) && cur_req && (burst_cnt == 4'(BURST_MAX - 1));
    assign take_gnt  = win_found && ((state == IDLE) || release_gnt || burst_end);
`else
    assign take_gnt  = win_found && ((state == IDLE) || release_gnt);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 2'd3;
`ifdef MUX_ARB_BURST_LIMIT_EN
            burst_cnt <= '0;
`endif
        end else begin
            out_valid <= (state == BUSY) && cur_req;
            if ((state == BUSY) && cur_req) begin
                out <= data[cur_idx];
            end

            if (take_gnt) begin
                state <= BUSY;
                gnt   <= 4'b0001 << win_idx;
                s0    <= win_idx[1];
                s1    <= win_idx[0];
                last  <= win_idx;
            end else if (release_gnt) begin
                state <= IDLE;
                gnt   <= '0;
            end

`ifdef MUX_ARB_BURST_LIMIT_EN
            // A burst that expires with nobody waiting simply starts a fresh window.
            if (take_gnt || release_gnt || burst_end) begin
                burst_cnt <= '0;
            end else if (state == BUSY) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Table-driven bench for mux_rr_arbiter; burst-limit vectors follow MUX_ARB_BURST_LIMIT_EN.
module tb_mux_rr_arbiter;
    typedef struct {
        logic [3:0] req;
        logic [3:0] data;  // {d, c, b, a}
        logic [3:0] gnt;
        logic [1:0] sel;   // {s0, s1}
        logic       out;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       a, b, c, d;
    logic [3:0] gnt;
    logic       s0, s1, out, out_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .s0(s0), .s1(s1), .out(out), .out_valid(out_valid)
    );

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] dt, input logic [3:0] g,
                                input logic [1:0] s, input logic o, input logic v);
        vec_t t;
        t.req  = r;
        t.data = dt;
        t.gnt  = g;
        t.sel  = s;
        t.out  = o;
        t.ov   = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input vec_t e);
        check({name, " gnt"}, gnt, e.gnt);
        check({name, " sel"}, {2'b00, s0, s1}, {2'b00, e.sel});
        check({name, " out"}, {3'b000, out}, {3'b000, e.out});
        check({name, " out_valid"}, {3'b000, out_valid}, {3'b000, e.ov});
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        req          = v.req;
        {d, c, b, a} = v.data;
        exp_q.push_back(v);
    endtask

    task automatic run_table(input string label);
        vec_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s[%0d]: scoreboard empty, expected an entry", label, i);
            end else begin
                e = exp_q.pop_front();
                check_outputs($sformatf("%s[%0d]", label, i), e);
            end
        end
        tbl.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        req          = '0;
        {d, c, b, a} = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req          = '0;
        {d, c, b, a} = '0;
        @(posedge clk);
        #1;
        check_outputs("reset", mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset for ten cycles.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0));
        run_table("idle");

        // Single requester a for three cycles, then release.
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0));
        run_table("single_a");

        // All four request; each drops in turn, handover without idle.
        apply_reset();
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 2'b01, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0010, 2'b01, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1100, 4'b0000, 4'b0100, 2'b10, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0));
        run_table("rr_1111");

        // c releases while a and d rise: d wins, then a.
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1));
        tbl.push_back(mk(4'b1001, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1001, 4'b1000, 4'b1000, 2'b11, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0));
        run_table("handover_cd");

        // a and b both request with a=1, b=0.
        apply_reset();
`ifdef MUX_ARB_BURST_LIMIT_EN
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0010, 2'b01, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0011, 4'b0001, 4'b0010, 2'b01, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0010, 2'b01, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0));
        run_table("burst_ab");
`else
        tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(4'b0011, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        tbl.push_back(mk(4'b0010, 4'b0001, 4'b0010, 2'b01, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0010, 4'b0001, 4'b0010, 2'b01, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0));
        run_table("hold_ab");
`endif

        // Asynchronous reset pulse while c is granted and streaming.
        apply_reset();
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b1));
        run_table("pre_async");
        #2;
        rst          = 1'b1;
        req          = '0;
        {d, c, b, a} = '0;
        #1;
        check_outputs("async_rst", mk(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0));
        #2;
        rst = 1'b0;
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0001, 2'b00, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1111, 4'b0001, 4'b0001, 2'b00, 1'b1, 1'b1));
        run_table("after_async");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, is the maximum consecutive granted cycles per requester when MUX_ARB_BURST_LIMIT_EN is defined; legal range 2..15.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines; bit0..bit3 belong to requesters a, b, c, d.
REQ-005 a, b, c, d  input  1 each  requester data bits, sampled only while that requester is granted.
REQ-006 gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-007 s0, s1  output  1 each  registered 4-to-1 select; {s0,s1}=00/01/10/11 selects a/b/c/d.
REQ-008 out  output  1  registered data bit from the granted requester.
REQ-009 out_valid  output  1  registered; high when out carries a fresh sample.

Function
REQ-010 The FSM SHALL have two states: IDLE (gnt=0) and BUSY (exactly one gnt bit high).
REQ-011 Round-robin search SHALL start at index (last+1) mod 4 and wrap 3->0; last is the most recently granted index.
REQ-012 In IDLE with req!=0 at an edge, the block SHALL enter BUSY with gnt/s0/s1 set to the winner at that edge (1-cycle grant latency).
REQ-013 In IDLE with req=0, the block SHALL stay in IDLE; gnt=0 and s0/s1 hold their last values.
REQ-014 In BUSY with granted req bit high at an edge, out SHALL load the granted data bit and out_valid SHALL be 1 after that edge.
REQ-015 In BUSY with granted req bit low at an edge, out_valid SHALL be 0 after that edge and out SHALL hold.
REQ-016 In BUSY with granted req bit low at an edge, the block SHALL hand over directly to the round-robin winner among the other requests, with no idle cycle; with no other request it SHALL return to IDLE.
REQ-017 On every grant change, last SHALL update to the new index in the same edge.
REQ-018 In IDLE, out_valid SHALL be 0.
REQ-019 Simultaneous requests SHALL be resolved solely by round-robin order; there is no fixed priority apart from the reset pointer.
REQ-020 A req bit that rises in the same cycle a grant is released SHALL be eligible in that cycle's arbitration.

Reset
REQ-021 While rst is high: state=IDLE, gnt=0000, s0=0, s1=0, out=0, out_valid=0, last=3 (requester a has first priority), burst counter=0.
REQ-022 Assertion of rst mid-burst SHALL clear all state immediately, without waiting for clk.
REQ-023 After rst falls, the first arbitration SHALL occur at the next rising edge of clk.

Configuration
REQ-024 Macro MUX_ARB_BURST_LIMIT_EN.
REQ-025 With MUX_ARB_BURST_LIMIT_EN defined, a 4-bit counter SHALL count granted BUSY cycles. It SHALL reset to 0 on every grant change.
REQ-026 With MUX_ARB_BURST_LIMIT_EN defined, when the counter reaches BURST_MAX-1 and another req bit is high, the grant SHALL be forced to the round-robin winner at the next edge, even if the current requester still requests.
REQ-027 With MUX_ARB_BURST_LIMIT_EN defined, when the counter reaches BURST_MAX-1 and no other request is pending, the grant SHALL continue and the counter SHALL restart at 0.
REQ-028 Without MUX_ARB_BURST_LIMIT_EN, no counter SHALL exist and a grant SHALL persist until the granted req bit drops.

Verification
REQ-029 Reset with req=0000 -> gnt=0000, s0=s1=0, out_valid=0, and it stays so for 10 cycles.
REQ-030 req=0001, a=1 for 3 cycles, then req=0000 -> gnt=0001 after edge 1; out=1 with out_valid=1 after edges 2-3; IDLE after req drops.
REQ-031 req=1111 held, burst limit off, then each requester drops its req in turn -> grant order a,b,c,d, with {s0,s1}=00,01,10,11, and no idle cycle between grants.
REQ-032 req=0011 held, burst limit on, BURST_MAX=4 -> gnt alternates 0001/0010 every 4 cycles; out follows a then b.
REQ-033 Grant on c (req=0100), then req changes to 1001 in the same cycle c drops -> next grant is d (0x8), not a.
REQ-034 rst pulsed high for 3 ns mid-BUSY between clock edges -> all outputs return to reset values immediately; re-arbitration starts from requester a.
